// File: rtl/mmp_iddmm_pkg.sv
// mmp_iddmm_pkg: shared FSM state encoding and core write-enable one-hot constants
package mmp_iddmm_pkg;
  typedef enum logic [2:0] {IDLE, LD_M1, LD_X, LD_Y, LD_M, REQ, WAIT, DRAIN} state_t;
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_X = 3'b001;
  localparam logic [2:0] WE_Y = 3'b010;
  localparam logic [2:0] WE_M = 3'b100;
endpackage

// File: rtl/simple_ram.sv
// simple_ram: D x W LUT RAM, synchronous write, asynchronous read
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module simple_ram #(
  parameter int W = 128,
  parameter int D = 32,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/mmp_iddmm_drv.sv
// mmp_iddmm_drv: streams m1/x/y/m operand words into a Montgomery core, collects and drains its result
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data operand stream;
// wr_ena/wr_addr/wr_x/wr_y/wr_m/wr_m1 core load port; task_req/task_grant/task_res/task_end core
// handshake; out_valid/out_ready/out_data/out_last result stream; busy, sticky err.
// Option: MMP_IDDMM_DRV_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT cycles.
module mmp_iddmm_drv
  import mmp_iddmm_pkg::*;
#(
  parameter int K = 128,
  parameter int N = 32,
  parameter int ADDR_W = $clog2(N),
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_data,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_grant,
  input  logic [K-1:0]      task_res,
  input  logic              task_end,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [K-1:0]      out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);
  localparam logic [ADDR_W:0] NF = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] NL = (ADDR_W+1)'(N-1);
  state_t state, nxt;
  logic [ADDR_W:0] cnt, rcnt, ocnt, rcnt_n;
  logic [N-1:0] vld;
  logic [K-1:0] rd;
  logic xfer, grant_ok, tmo;
  // cnt reaches N in LD_M only after the last m word, holding in_ready low for the write cycle
  assign in_ready = state inside {LD_M1, LD_X, LD_Y} || (state == LD_M && cnt != NF);
  assign xfer = in_valid && in_ready;
  assign grant_ok = state == WAIT && task_grant && rcnt != NF;
  assign rcnt_n = rcnt + (ADDR_W+1)'(grant_ok);
  assign busy = state != IDLE;
  assign task_req = state == REQ;
  assign out_valid = state == DRAIN;
  assign out_last = out_valid && ocnt == NL;
  // slots never granted since LD_M1 entry read as zero
  assign out_data = (out_valid && vld[ocnt[ADDR_W-1:0]]) ? rd : '0;
`ifdef MMP_IDDMM_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk)
    tcnt <= (rst || state != WAIT) ? '0 : tcnt + 1'b1;
  assign tmo = state == WAIT && !task_end && tcnt == TW'(TIMEOUT-1);
`else
  assign tmo = 1'b0;
`endif
  simple_ram #(.W(K), .D(N), .AW(ADDR_W)) u_buf (
    .clk(clk),
    .we(grant_ok),
    .waddr(rcnt[ADDR_W-1:0]),
    .wdata(task_res),
    .raddr(ocnt[ADDR_W-1:0]),
    .rdata(rd)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = in_valid ? LD_M1 : IDLE;
      LD_M1: nxt = xfer ? LD_X : LD_M1;
      LD_X:  nxt = (xfer && cnt == NL) ? LD_Y : LD_X;
      LD_Y:  nxt = (xfer && cnt == NL) ? LD_M : LD_Y;
      LD_M:  nxt = cnt == NF ? REQ : LD_M;
      REQ:   nxt = WAIT;
      WAIT:  nxt = task_end ? DRAIN : tmo ? IDLE : WAIT;
      DRAIN: nxt = (out_ready && out_last) ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rcnt <= '0;
      ocnt <= '0;
      vld <= '0;
      err <= 1'b0;
      wr_ena <= WE_NONE;
      wr_addr <= '0;
      wr_x <= '0;
      wr_y <= '0;
      wr_m <= '0;
      wr_m1 <= '0;
    end else begin
      state <= nxt;
      wr_ena <= WE_NONE;
      if (state == IDLE && in_valid) begin
        cnt <= '0;
        rcnt <= '0;
        ocnt <= '0;
        vld <= '0;
        err <= 1'b0;
      end
      if (xfer && state == LD_M1) wr_m1 <= in_data;
      if (xfer && state inside {LD_X, LD_Y, LD_M}) begin
        wr_addr <= cnt[ADDR_W-1:0];
        wr_ena <= state == LD_X ? WE_X : state == LD_Y ? WE_Y : WE_M;
        cnt <= (state != LD_M && cnt == NL) ? '0 : cnt + 1'b1;
      end
      if (xfer && state == LD_X) wr_x <= in_data;
      if (xfer && state == LD_Y) wr_y <= in_data;
      if (xfer && state == LD_M) wr_m <= in_data;
      if (grant_ok) vld[rcnt[ADDR_W-1:0]] <= 1'b1;
      rcnt <= state == WAIT ? rcnt_n : (state == IDLE && in_valid) ? '0 : rcnt;
      if (state == WAIT && task_grant && rcnt == NF) err <= 1'b1;
      if (state == WAIT && task_end && rcnt_n != NF) err <= 1'b1;
      if (tmo) err <= 1'b1;
      if (out_valid && out_ready) ocnt <= ocnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mmp_iddmm_drv.sv
// tb_mmp_iddmm_drv: directed self-checking bench for mmp_iddmm_drv (N=4, K=128, TIMEOUT=100)
module tb_mmp_iddmm_drv;
  localparam int K = 128;
  localparam int N = 4;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, task_req, task_grant, task_end;
  logic out_valid, out_ready, out_last, busy, err;
  logic [K-1:0] in_data, wr_x, wr_y, wr_m, wr_m1, task_res, out_data;
  logic [2:0] wr_ena;
  logic [AW-1:0] wr_addr;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mmp_iddmm_drv #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
    .task_req(task_req), .task_grant(task_grant), .task_res(task_res), .task_end(task_end),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // streams words 1..13; ends in WAIT
  task automatic load(input bit c);
    in_valid = 1'b1;
    in_data = 128'd1;
    tick;
    tick;
    if (c) chk("m1", wr_m1, 128'd1);
    in_data = 128'd2;
    for (int i = 0; i < 12; i++) begin
      tick;
      in_data = 128'(i + 3);
      if (c) begin
        chk("wr_ena", 128'(wr_ena), 128'(3'b001 << (i / 4)));
        chk("wr_addr", 128'(wr_addr), 128'(i % 4));
        chk("wr_data", i < 4 ? wr_x : i < 8 ? wr_y : wr_m, 128'(i + 2));
        chk("task_req_early", 128'(task_req), 128'd0);
      end
    end
    in_valid = 1'b0;
    if (c) chk("in_ready_last", 128'(in_ready), 128'd0);
    tick;
    if (c) begin
      chk("task_req_on", 128'(task_req), 128'd1);
      chk("wr_ena_req", 128'(wr_ena), 128'd0);
    end
    tick;
    if (c) begin
      chk("task_req_off", 128'(task_req), 128'd0);
      chk("busy_wait", 128'(busy), 128'd1);
    end
  endtask
  task automatic grants(input int n);
    for (int i = 0; i < n; i++) begin
      task_grant = 1'b1;
      task_res = 128'(8'hA0 + i);
      tick;
    end
    task_grant = 1'b0;
    task_end = 1'b1;
    tick;
    task_end = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    task_grant = 1'b0;
    task_res = '0;
    task_end = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_wr_ena", 128'(wr_ena), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_wr_m1", wr_m1, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    rst = 1'b0;
    tick;
    // full transaction with back-to-back drain
    load(1'b1);
    grants(4);
    out_ready = 1'b1;
    chk("d_valid", 128'(out_valid), 128'd1);
    for (int i = 0; i < 4; i++) begin
      chk("d_data", out_data, 128'(8'hA0 + i));
      chk("d_last", 128'(out_last), 128'(i == 3));
      tick;
    end
    chk("d_idle", 128'(busy), 128'd0);
    chk("d_err", 128'(err), 128'd0);
    // backpressure on word 1
    load(1'b0);
    grants(4);
    chk("bp_w0", out_data, 128'hA0);
    tick;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold", out_data, 128'hA1);
      chk("bp_last", 128'(out_last), 128'd0);
    end
    out_ready = 1'b1;
    tick;
    chk("bp_w2", out_data, 128'hA2);
    tick;
    chk("bp_w3", out_data, 128'hA3);
    chk("bp_w3_last", 128'(out_last), 128'd1);
    tick;
    chk("bp_idle", 128'(busy), 128'd0);
    // missing grant
    load(1'b0);
    chk("mis_err_clr", 128'(err), 128'd0);
    grants(3);
    chk("mis_err", 128'(err), 128'd1);
    for (int i = 0; i < 4; i++) begin
      chk("mis_data", out_data, i < 3 ? 128'(8'hA0 + i) : 128'd0);
      tick;
    end
    // extra grant discarded
    load(1'b0);
    chk("ovf_err_clr", 128'(err), 128'd0);
    grants(5);
    chk("ovf_err", 128'(err), 128'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ovf_data", out_data, 128'(8'hA0 + i));
      tick;
    end
    // grant/end ignored outside WAIT
    task_grant = 1'b1;
    task_end = 1'b1;
    tick;
    tick;
    task_grant = 1'b0;
    task_end = 1'b0;
    chk("ign_busy", 128'(busy), 128'd0);
    chk("ign_valid", 128'(out_valid), 128'd0);
    // reset during LD_Y
    in_valid = 1'b1;
    in_data = 128'd1;
    tick;
    for (int i = 0; i < 6; i++) begin
      tick;
      in_data = 128'(i + 2);
    end
    chk("ab_in_y", 128'(wr_ena), 128'b010);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("ab_wr_ena", 128'(wr_ena), 128'd0);
    chk("ab_busy", 128'(busy), 128'd0);
    chk("ab_wr_x", wr_x, 128'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("ab_quiet", 128'({wr_ena, task_req}), 128'd0);
    end
    load(1'b0);
    chk("ab_m1", wr_m1, 128'd1);
    grants(4);
    for (int i = 0; i < 4; i++) begin
      chk("ab_data", out_data, 128'(8'hA0 + i));
      tick;
    end
    chk("ab_idle", 128'(busy), 128'd0);
    chk("ab_err", 128'(err), 128'd0);
    // watchdog
    load(1'b0);
    for (int i = 0; i < 150; i++) tick;
`ifdef MMP_IDDMM_DRV_TIMEOUT_EN
    chk("to_busy", 128'(busy), 128'd0);
    chk("to_err", 128'(err), 128'd1);
`else
    chk("to_busy", 128'(busy), 128'd1);
    chk("to_err", 128'(err), 128'd0);
`endif
    chk("to_valid", 128'(out_valid), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
